mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Two-master round-robin arbiter that shares the system's single native memory port (valid/ready, addr, wdata, wstrb, rdata) between the CPU (master 0) and a secondary requester such as a loader or DMA (master 1). It sits between the requesters and the memory/peripheral decode inside the system top.
A per-transaction watchdog completes a stalled access with an error word, so a missing slave response ends as a trap-visible event instead of a simulation hang.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; wstrb width is DATA_W/8
TIMEOUT, 255, cycles a granted access may wait for s_ready before forced completion; 0 disables the watchdog
ERR_WORD, 32'hDEAD_BEEF, rdata returned on a timed-out access

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
m0_valid  in  1  master 0 request; held until m0_ready
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_wstrb  in  DATA_W/8  master 0 byte strobes; 0 means read
m0_ready  out  1  one-cycle completion pulse to master 0
m0_rdata  out  DATA_W  read data to master 0, valid with m0_ready
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  same as m0, for master 1
s_valid  out  1  request to shared slave
s_addr  out  ADDR_W  muxed address
s_wdata  out  DATA_W  muxed write data
s_wstrb  out  DATA_W/8  muxed strobes
s_ready  in  1  slave completion
s_rdata  in  DATA_W  slave read data
timeout_err  out  1  one-cycle pulse when the watchdog fires
grant_id  out  1  master currently owning the bus; debug only

Behaviour:
- Reset (async, resetn low): state IDLE, last_grant=1 so master 0 wins the first tie, watchdog counter=0. Outputs s_valid, m0_ready, m1_ready, timeout_err are 0; grant_id is 0. rdata outputs are don't-care while ready is 0.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - Only one valid: go to that master's GNTx.
  - Both valid: go to the GNT of the master opposite last_grant.
  - Otherwise stay in IDLE.
  - Arbitration costs exactly 1 cycle. s_valid is never asserted in IDLE.
- GNTx:
  - s_valid = mx_valid. s_addr, s_wdata and s_wstrb are the granted master's signals, driven combinationally.
  - mx_ready = s_ready. mx_rdata = s_rdata in the same cycle, with no added latency on the response path.
  - The non-granted master's ready is always 0.
- On s_ready in GNTx: last_grant=x, counter cleared, return to IDLE. The next request is therefore granted no earlier than 2 cycles later, which guarantees fairness under continuous contention: strict alternation.
- Watchdog (TIMEOUT>0):
  - The counter increments each GNTx cycle with s_ready=0.
  - When it reaches TIMEOUT, in that cycle: mx_ready=1, mx_rdata=ERR_WORD, timeout_err=1, s_valid forced 0. Then return to IDLE with last_grant=x.
  - If s_ready and the timeout occur in the same cycle, s_ready wins: normal completion, no timeout_err.
  - Counter width is clog2(TIMEOUT+1).
- Granted master drops valid before ready (protocol violation): s_valid falls with it, FSM returns to IDLE next cycle, no ready is issued, and last_grant is not updated.
- s_ready while in IDLE is ignored.
- Reset asserted mid-transaction: immediate return to the reset state. Any in-flight slave access is abandoned and no ready is issued.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state enum (IDLE/GNT0/GNT1);
  - the ERR_WORD default constant;
  - a mem_req_t struct {addr, wdata, wstrb}, so muxing is one assignment.
- One natural sub-module: mem_bus_watchdog (counter, clear/enable inputs, expired output), reusable for other bus bridges.

Test Plan:
- Single master: m0 read addr 0x100; slave answers rdata 0x12345678 after 3 cycles -> s_valid high from cycle 1 after m0_valid; m0_ready pulses once with 0x12345678; m1_ready stays 0.
- Contention: m0 and m1 both valid continuously, slave ready after 1 cycle -> grants alternate m0, m1, m0, m1, and each ready is a single pulse.
- Write pass-through: m1 writes 0xCAFEF00D to 0x2000 with wstrb 4'b0011 -> s_addr/s_wdata/s_wstrb match exactly while grant_id=1.
- Timeout: TIMEOUT=8, slave never responds -> m0_ready and timeout_err pulse together on the 8th stalled cycle, m0_rdata=0xDEADBEEF; a pending m1 is granted next.
- Race: s_ready asserted exactly on the TIMEOUT cycle -> normal completion with slave data, timeout_err stays 0.
- Reset mid-access: pull resetn low during GNT1 with slave stalled -> s_valid and all ready outputs drop immediately. After release with both masters valid, m0 is granted first.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master memory bus arbiter.
// Request bundle, arbiter states and default error word.
package mem_bus_pkg;

   localparam int REQ_ADDR_W = 32;
   localparam int REQ_DATA_W = 32;

   localparam logic [31:0] ERR_WORD_DEF = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [REQ_ADDR_W-1:0]   addr;
      logic [REQ_DATA_W-1:0]   wdata;
      logic [REQ_DATA_W/8-1:0] wstrb;
   } mem_req_t;

endpackage

// File: rtl/mem_bus_watchdog.sv
// Stall counter for bus bridges: expired pulses on the
// TIMEOUT-th consecutive enabled cycle; TIMEOUT=0 disables it.
module mem_bus_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST =
      CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Fires in the same cycle the count reaches TIMEOUT.
   assign expired = (TIMEOUT > 0) && en && (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto one native memory port,
// with a per-access watchdog that completes stalls with ERR_WORD.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter logic [DATA_W-1:0] ERR_WORD = ERR_WORD_DEF
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                m0_valid,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic                m0_ready,
   output logic [DATA_W-1:0]   m0_rdata,
   input  logic                m1_valid,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_ready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                s_valid,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_ready,
   input  logic [DATA_W-1:0]   s_rdata,
   output logic                timeout_err,
   output logic                grant_id
);

   localparam int SW = DATA_W / 8;
   localparam int RSW = REQ_DATA_W / 8;

   arb_state_t state, state_nxt;
   logic       last_grant, last_grant_nxt;
   logic       gvalid, done, expired;
   mem_req_t   req0, req1, req_g;

   assign req0 = '{addr:  REQ_ADDR_W'(m0_addr),
                   wdata: REQ_DATA_W'(m0_wdata),
                   wstrb: RSW'(m0_wstrb)};
   assign req1 = '{addr:  REQ_ADDR_W'(m1_addr),
                   wdata: REQ_DATA_W'(m1_wdata),
                   wstrb: RSW'(m1_wstrb)};

   assign gvalid = (state == GNT0 && m0_valid) ||
                   (state == GNT1 && m1_valid);
   assign done   = gvalid && (s_ready || expired);

   mem_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (!gvalid),
      .en      (gvalid && !s_ready),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // A dropped request abandons the grant without touching last_grant.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      unique case (state)
         IDLE: begin
            if (m0_valid && m1_valid)
               state_nxt = last_grant ? GNT0 : GNT1;
            else if (m0_valid)
               state_nxt = GNT0;
            else if (m1_valid)
               state_nxt = GNT1;
         end
         GNT0: begin
            if (!m0_valid) begin
               state_nxt = IDLE;
            end else if (done) begin
               state_nxt      = IDLE;
               last_grant_nxt = 1'b0;
            end
         end
         GNT1: begin
            if (!m1_valid) begin
               state_nxt = IDLE;
            end else if (done) begin
               state_nxt      = IDLE;
               last_grant_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_g       = (state == GNT1) ? req1 : req0;
      s_valid     = gvalid && !expired;
      s_addr      = ADDR_W'(req_g.addr);
      s_wdata     = DATA_W'(req_g.wdata);
      s_wstrb     = SW'(req_g.wstrb);
      m0_ready    = (state == GNT0) && done;
      m1_ready    = (state == GNT1) && done;
      m0_rdata    = expired ? ERR_WORD : s_rdata;
      m1_rdata    = expired ? ERR_WORD : s_rdata;
      timeout_err = expired;
      grant_id    = (state == GNT1);
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with TIMEOUT=8:
// single read, contention, write mux, timeout, race, async reset.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic        timeout_err, grant_id;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .m0_valid    (m0_valid),
      .m0_addr     (m0_addr),
      .m0_wdata    (m0_wdata),
      .m0_wstrb    (m0_wstrb),
      .m0_ready    (m0_ready),
      .m0_rdata    (m0_rdata),
      .m1_valid    (m1_valid),
      .m1_addr     (m1_addr),
      .m1_wdata    (m1_wdata),
      .m1_wstrb    (m1_wstrb),
      .m1_ready    (m1_ready),
      .m1_rdata    (m1_rdata),
      .s_valid     (s_valid),
      .s_addr      (s_addr),
      .s_wdata     (s_wdata),
      .s_wstrb     (s_wstrb),
      .s_ready     (s_ready),
      .s_rdata     (s_rdata),
      .timeout_err (timeout_err),
      .grant_id    (grant_id)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      resetn   = 1'b0;
      m0_valid = 1'b0; m1_valid = 1'b0;
      m0_addr  = '0;   m1_addr  = '0;
      m0_wdata = '0;   m1_wdata = '0;
      m0_wstrb = '0;   m1_wstrb = '0;
      s_ready  = 1'b0; s_rdata  = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s_valid", s_valid, 0);
      chk("rst_m0_ready", m0_ready, 0);
      chk("rst_m1_ready", m1_ready, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_grant", grant_id, 0);
      tick();
      resetn = 1'b1;

      // single master read, slave answers on 3rd grant cycle
      m0_valid = 1'b1;
      m0_addr  = 32'h100;
      @(negedge clk);
      chk("t1_idle_s_valid", s_valid, 0);
      tick();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t1_s_valid", s_valid, 1);
         chk("t1_s_addr", s_addr, 32'h100);
         chk("t1_stall_ready", m0_ready, 0);
         tick();
      end
      s_ready = 1'b1;
      s_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("t1_m0_ready", m0_ready, 1);
      chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
      chk("t1_m1_ready", m1_ready, 0);
      tick();
      m0_valid = 1'b0;
      s_ready  = 1'b0;
      @(negedge clk);
      chk("t1_single_pulse", m0_ready, 0);
      chk("t1_after_s_valid", s_valid, 0);

      // fresh reset, then continuous contention
      tick();
      resetn = 1'b0;
      tick();
      resetn   = 1'b1;
      m0_valid = 1'b1;
      m1_valid = 1'b1;
      m0_addr  = 32'h400;
      m1_addr  = 32'h800;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t2_idle_s_valid", s_valid, 0);
         chk("t2_idle_ready", {m1_ready, m0_ready}, 0);
         tick();
         s_ready = 1'b1;
         s_rdata = 32'h1000 + k;
         @(negedge clk);
         chk("t2_grant_id", grant_id, k % 2);
         chk("t2_m0_ready", m0_ready, (k % 2) == 0);
         chk("t2_m1_ready", m1_ready, (k % 2) == 1);
         chk("t2_s_addr", s_addr,
             (k % 2) ? 32'h800 : 32'h400);
         tick();
         s_ready = 1'b0;
      end

      // m1 write pass-through
      m0_valid = 1'b0;
      m1_addr  = 32'h2000;
      m1_wdata = 32'hCAFE_F00D;
      m1_wstrb = 4'b0011;
      @(negedge clk);
      tick();
      s_ready = 1'b1;
      @(negedge clk);
      chk("t3_grant_id", grant_id, 1);
      chk("t3_s_valid", s_valid, 1);
      chk("t3_s_addr", s_addr, 32'h2000);
      chk("t3_s_wdata", s_wdata, 32'hCAFE_F00D);
      chk("t3_s_wstrb", s_wstrb, 4'b0011);
      chk("t3_m1_ready", m1_ready, 1);
      chk("t3_m0_ready", m0_ready, 0);
      tick();
      s_ready  = 1'b0;
      m1_valid = 1'b0;
      m1_wstrb = 4'b0000;

      // timeout on m0 with m1 pending
      m0_valid = 1'b1;
      m0_addr  = 32'h300;
      m1_valid = 1'b1;
      m1_addr  = 32'h304;
      @(negedge clk);
      tick();
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk("t4_grant_id", grant_id, 0);
         chk("t4_stall_ready", m0_ready, 0);
         chk("t4_stall_err", timeout_err, 0);
         chk("t4_stall_s_valid", s_valid, 1);
         tick();
      end
      @(negedge clk);
      chk("t4_m0_ready", m0_ready, 1);
      chk("t4_timeout_err", timeout_err, 1);
      chk("t4_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk("t4_s_valid_forced", s_valid, 0);
      chk("t4_m1_ready", m1_ready, 0);
      tick();
      m0_valid = 1'b0;
      @(negedge clk);
      chk("t4_idle_err", timeout_err, 0);
      chk("t4_idle_ready", m0_ready, 0);
      tick();

      // m1 granted next; s_ready lands on the timeout cycle
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk("t5_grant_id", grant_id, 1);
         chk("t5_stall_ready", m1_ready, 0);
         tick();
      end
      s_ready = 1'b1;
      s_rdata = 32'hA5A5_0001;
      @(negedge clk);
      chk("t5_m1_ready", m1_ready, 1);
      chk("t5_m1_rdata", m1_rdata, 32'hA5A5_0001);
      chk("t5_timeout_err", timeout_err, 0);
      tick();
      s_ready  = 1'b0;
      m1_valid = 1'b0;

      // async reset in the middle of a stalled m1 access
      m1_valid = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      chk("t6_pre_s_valid", s_valid, 1);
      resetn  = 1'b0;
      s_ready = 1'b1;
      #1;
      chk("t6_rst_s_valid", s_valid, 0);
      chk("t6_rst_m0_ready", m0_ready, 0);
      chk("t6_rst_m1_ready", m1_ready, 0);
      chk("t6_rst_grant", grant_id, 0);
      chk("t6_rst_err", timeout_err, 0);
      m0_valid = 1'b1;
      s_ready  = 1'b0;
      tick();
      resetn = 1'b1;
      @(negedge clk);
      chk("t6_idle_s_valid", s_valid, 0);
      tick();
      @(negedge clk);
      chk("t6_grant_id", grant_id, 0);
      chk("t6_s_valid", s_valid, 1);
      chk("t6_s_addr", s_addr, 32'h300);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
